ship_ctrl: RTL and testbench
============================

SHIP_CTRL -- requirements
Module: ship_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
 XW, 5, width of ship_x in bits
 X_MIN, 0, leftmost legal position
 X_MAX, 31, rightmost legal position (X_MIN < X_MAX < 2^XW)
 X_INIT, 15, position after reset (X_MIN <= X_INIT <= X_MAX)
 STEP, 1, positions moved per move event (1 <= STEP <= X_MAX-X_MIN)
 HOLD_DELAY, 4, enable ticks after the first move before auto-repeat starts (>=1)
 REPEAT_RATE, 2, enable ticks between auto-repeat moves (>=1)
 FIRE_COOLDOWN, 8, enable ticks of fire lockout after a shot (>=1)
REQ-002 Ports, one per line (name, direction, width, meaning):
 clk_25MHz  in  1  system clock; all state changes on its rising edge
 reset  in  1  asynchronous, active-high reset
 enable  in  1  game tick strobe; movement and cooldown advance only on clocks with enable=1
 left_debounced  in  1  left button level, already debounced
 right_debounced  in  1  right button level, already debounced
 fire_debounced  in  1  fire button level, already debounced
 missile_busy  in  1  a ship missile is in flight; blocks firing
 ship_x  out  XW  current ship position, registered
 fire_req  out  1  one-clock pulse requesting a missile launch at ship_x
 moving  out  1  high while the move FSM is in HOLD or REPEAT

Function
REQ-003 Direction per tick: left only -> dir=L; right only -> dir=R; both or neither -> none.
REQ-004 Move FSM states IDLE, HOLD, REPEAT, plus a registered last_dir and an auto-repeat counter cnt sized for max(HOLD_DELAY, REPEAT_RATE).
REQ-005 Clocks with enable=0 change nothing in the move FSM, cnt or ship_x.
REQ-006 On an enable tick with dir=none: state -> IDLE, cnt -> 0, ship_x unchanged.
REQ-007 On an enable tick with dir valid and (state=IDLE or dir != last_dir): one move in dir, state -> HOLD, cnt -> 0, last_dir -> dir.
REQ-008 HOLD, same dir: if cnt=HOLD_DELAY-1 then move, cnt -> 0, state -> REPEAT; else cnt+1.
REQ-009 REPEAT, same dir: if cnt=REPEAT_RATE-1 then move, cnt -> 0; else cnt+1.
REQ-010 A move is computed in XW+1 bits and saturates: right gives min(ship_x+STEP, X_MAX); left gives max(ship_x-STEP, X_MIN); ship_x never wraps and never leaves [X_MIN, X_MAX].
REQ-011 A move at a bound that yields an unchanged position still advances FSM and cnt normally.
REQ-012 ship_x takes its new value on the clock edge that samples the enable tick; it is valid on the next cycle.
REQ-013 moving = 1 iff state is HOLD or REPEAT.
REQ-014 Fire edge: fire_prev registers fire_debounced every clock; rise = fire_debounced & ~fire_prev, evaluated every clock regardless of enable.
REQ-015 On rise with missile_busy=0 and cooldown=0: fire_req=1 on the next cycle for exactly one clock, and cooldown is loaded with FIRE_COOLDOWN.
REQ-016 A rise with missile_busy=1 or cooldown!=0 is dropped, not queued.
REQ-017 Cooldown decrements by 1 on each enable tick while nonzero and saturates at 0.
REQ-018 Firing and movement are independent; both may act in the same clock.

Reset
REQ-019 While reset=1, regardless of clock: ship_x=X_INIT, fire_req=0, moving=0, state=IDLE, cnt=0, last_dir=R, cooldown=0, fire_prev=1. A fire button held through reset therefore does not fire.
REQ-020 Reset asserted mid-HOLD, mid-REPEAT or mid-cooldown abandons all progress; after release, behaviour is as from power-up.

Verification (default parameters, enable=1 every clock unless stated)
REQ-021 Reset, then right held for 10 ticks -> ship_x sequence 16, 16, 16, 16, 17, 17, 18, 18, 19, 19; moving=1 from the first tick.
REQ-022 From ship_x=30, right held for 12 ticks -> ship_x reaches 31 and stays 31; left at ship_x=0 -> stays 0; never wraps.
REQ-023 Left and right both held for 20 ticks, plus enable=0 with right held for 20 clocks -> ship_x unchanged, moving=0 for both-held.
REQ-024 Right held into REPEAT, then switched to left -> one immediate left move on the switch tick, state HOLD, next left move 4 ticks later.
REQ-025 Fire rise -> fire_req high for 1 clock; rises at tick 3 and tick 7 after it -> ignored; rise at tick 9 -> fires; rise with missile_busy=1 -> no fire_req.
REQ-026 Fire held through reset release -> no fire_req; reset asserted during REPEAT at ship_x=20 -> ship_x=15 immediately (asynchronous) and moving=0.

Source files
------------

// File: rtl/ship_ctrl.sv
// ship_ctrl: player ship position and fire control.
//   Left/right buttons move the ship on game ticks (enable). Holding a direction
//   gives one immediate move, then auto-repeat after HOLD_DELAY ticks, then a move
//   every REPEAT_RATE ticks. Position saturates at [X_MIN, X_MAX].
//   A fire button rising edge raises fire_req for one clock, provided no missile
//   is in flight and the cooldown has expired.
// Ports:
//   clk_25MHz, reset (async, active high)
//   enable          game tick strobe
//   left/right/fire_debounced  button levels
//   missile_busy    blocks firing
//   ship_x          registered position
//   fire_req        one-clock launch pulse
//   moving          move FSM in HOLD or REPEAT
module ship_ctrl #(
  parameter int XW            = 5,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = 31,
  parameter int X_INIT        = 15,
  parameter int STEP          = 1,
  parameter int HOLD_DELAY    = 4,
  parameter int REPEAT_RATE   = 2,
  parameter int FIRE_COOLDOWN = 8
) (
  input  logic          clk_25MHz,
  input  logic          reset,
  input  logic          enable,
  input  logic          left_debounced,
  input  logic          right_debounced,
  input  logic          fire_debounced,
  input  logic          missile_busy,
  output logic [XW-1:0] ship_x,
  output logic          fire_req,
  output logic          moving
);

  localparam int MAXC = (HOLD_DELAY > REPEAT_RATE) ? HOLD_DELAY : REPEAT_RATE;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int FW   = $clog2(FIRE_COOLDOWN + 1);

  localparam logic [XW:0]   XMIN_W = (XW+1)'(X_MIN);
  localparam logic [XW:0]   XMAX_W = (XW+1)'(X_MAX);
  localparam logic [XW:0]   STEP_W = (XW+1)'(STEP);
  localparam logic [XW-1:0] XMIN_N = XW'(X_MIN);
  localparam logic [XW-1:0] XMAX_N = XW'(X_MAX);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_e;
  typedef enum logic {DIR_R, DIR_L} dir_e;

  state_e        state_q, state_d;
  dir_e          last_dir_q, last_dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [FW-1:0] cool_q, cool_d;
  logic          fire_prev_q;
  logic          fire_req_q;

  // Direction decode: exactly one button pressed gives a valid direction.
  logic dir_vld;
  dir_e dir;
  assign dir_vld = left_debounced ^ right_debounced;
  assign dir     = left_debounced ? DIR_L : DIR_R;

  // Saturating moves in XW+1 bits. A left move that borrows sets the MSB,
  // which is treated as below X_MIN.
  logic [XW:0]   sum_r, dif_l;
  logic [XW-1:0] x_right, x_left, x_moved;
  assign sum_r   = {1'b0, x_q} + STEP_W;
  assign dif_l   = {1'b0, x_q} - STEP_W;
  assign x_right = (sum_r > XMAX_W) ? XMAX_N : sum_r[XW-1:0];
  assign x_left  = (dif_l[XW] || (dif_l < XMIN_W)) ? XMIN_N : dif_l[XW-1:0];
  assign x_moved = (dir == DIR_L) ? x_left : x_right;

  // Move FSM next state.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    if (enable) begin
      if (!dir_vld) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else if (state_q == S_IDLE || dir != last_dir_q) begin
        // Fresh press or reversal: move immediately and restart the hold delay.
        x_d        = x_moved;
        state_d    = S_HOLD;
        cnt_d      = '0;
        last_dir_d = dir;
      end else if (state_q == S_HOLD) begin
        if (cnt_q == HOLD_LAST) begin
          x_d     = x_moved;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        if (cnt_q == REP_LAST) begin
          x_d   = x_moved;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Fire: edge detect runs every clock; cooldown counts game ticks.
  logic rise, fire_now;
  assign rise     = fire_debounced & ~fire_prev_q;
  assign fire_now = rise & ~missile_busy & (cool_q == '0);

  always_comb begin
    cool_d = cool_q;
    if (fire_now)
      cool_d = FW'(FIRE_COOLDOWN);
    else if (enable && cool_q != '0)
      cool_d = cool_q - FW'(1);
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_dir_q  <= DIR_R;
      cnt_q       <= '0;
      x_q         <= XW'(X_INIT);
      cool_q      <= '0;
      fire_prev_q <= 1'b1;  // a button held through reset must not fire
      fire_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      cool_q      <= cool_d;
      fire_prev_q <= fire_debounced;
      fire_req_q  <= fire_now;
    end
  end

  assign ship_x   = x_q;
  assign fire_req = fire_req_q;
  assign moving   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ship_ctrl.sv
// Directed testbench for ship_ctrl with default parameters.
module tb_ship_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       left = 1'b0, right = 1'b0, fire = 1'b0, busy = 1'b0;
  logic [4:0] ship_x;
  logic       fire_req, moving;

  int n_chk = 0;
  int n_err = 0;

  ship_ctrl dut (
    .clk_25MHz      (clk),
    .reset          (reset),
    .enable         (enable),
    .left_debounced (left),
    .right_debounced(right),
    .fire_debounced (fire),
    .missile_busy   (busy),
    .ship_x         (ship_x),
    .fire_req       (fire_req),
    .moving         (moving)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_x(input int target, input int lim);
    int n = 0;
    while (int'(ship_x) != target && n < lim) begin
      tick();
      n++;
    end
    chk("reach_x", ship_x, target);
  endtask

  int seq21 [10] = '{16, 16, 16, 16, 17, 17, 18, 18, 19, 19};

  initial begin
    // Reset state (asynchronous)
    #5 reset = 1'b1;
    #1;
    chk("rst_x", ship_x, 15);
    chk("rst_fire", fire_req, 0);
    chk("rst_moving", moving, 0);
    tick(); tick();
    reset = 1'b0;

    // Right held 10 ticks
    right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_seq_x", ship_x, seq21[i]);
      chk("hold_seq_mv", moving, 1);
    end
    right = 1'b0;
    tick();
    chk("release_x", ship_x, 19);
    chk("release_mv", moving, 0);

    // Both held: no movement
    left = 1'b1; right = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("both_mv", moving, 0);
    end
    chk("both_x", ship_x, 19);
    left = 1'b0;

    // enable low: nothing moves
    enable = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("noen_x", ship_x, 19);
    chk("noen_mv", moving, 0);
    enable = 1'b1; right = 1'b0;
    tick();

    // Right saturation
    right = 1'b1;
    wait_x(30, 40);
    right = 1'b0;
    tick();
    chk("at30_x", ship_x, 30);
    right = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("sat_r_x", ship_x, 31);
    end
    right = 1'b0;
    tick();

    // Left saturation
    left = 1'b1;
    wait_x(0, 100);
    left = 1'b0;
    tick();
    left = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("sat_l_x", ship_x, 0);
    end
    chk("sat_l_mv", moving, 1);
    left = 1'b0;
    tick();

    // Reversal from REPEAT
    right = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rev_pre_x", ship_x, 2);
    right = 1'b0; left = 1'b1;
    tick();
    chk("rev_now_x", ship_x, 1);
    chk("rev_now_mv", moving, 1);
    tick(); tick(); tick();
    chk("rev_hold_x", ship_x, 1);
    tick();
    chk("rev_next_x", ship_x, 0);
    left = 1'b0;
    tick();

    // Fire and cooldown
    fire = 1'b1; tick(); chk("fire0", fire_req, 1);
    fire = 1'b0; tick(); chk("fire0_pulse", fire_req, 0);
    tick();
    fire = 1'b1; tick(); chk("fire3_drop", fire_req, 0);
    fire = 1'b0; tick(); tick(); tick();
    fire = 1'b1; tick(); chk("fire7_drop", fire_req, 0);
    fire = 1'b0; tick();
    fire = 1'b1; tick(); chk("fire9", fire_req, 1);
    fire = 1'b0; tick(); chk("fire9_pulse", fire_req, 0);
    for (int i = 0; i < 10; i++) tick();

    // missile_busy blocks and rise is not queued
    busy = 1'b1; fire = 1'b1; tick(); chk("busy_drop", fire_req, 0);
    busy = 1'b0; fire = 1'b0; tick(); chk("busy_noq1", fire_req, 0);
    tick(); chk("busy_noq2", fire_req, 0);
    fire = 1'b1; tick(); chk("fire_after_busy", fire_req, 1);
    fire = 1'b0; tick();

    // Reset mid-cooldown clears it
    #10 reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fire = 1'b1; tick(); chk("fire_after_rst", fire_req, 1);
    fire = 1'b0; tick();

    // Fire held through reset
    fire = 1'b1;
    #10 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick(); chk("held_rst_f1", fire_req, 0);
    tick(); chk("held_rst_f2", fire_req, 0);
    chk("held_rst_x", ship_x, 15);
    fire = 1'b0;
    tick();

    // Reset during REPEAT at 20
    right = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("rep20_x", ship_x, 20);
    chk("rep20_mv", moving, 1);
    #10 reset = 1'b1;
    #1;
    chk("async_rst_x", ship_x, 15);
    chk("async_rst_mv", moving, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    chk("post_rst_x", ship_x, 16);
    chk("post_rst_mv", moving, 1);
    right = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
